// File: rtl/multi_bounded_sample_counter.sv
// Array of independent bounded up-counters. Each channel saturates or wraps at its bound
// and can capture its pre-increment count into a sample register.
module multi_bounded_sample_counter #(
    parameter int WIDTH       = 11,
    parameter int CHANNELS    = 4,
    parameter int RESET_BOUND = 500,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          inc_en,
    input  logic [CHANNELS-1:0]          sel,
    input  logic                         wrap_mode,
    input  logic                         bound_we,
    input  logic [CW-1:0]                bound_ch,
    input  logic [WIDTH-1:0]             bound_data,
    output logic [CHANNELS*WIDTH-1:0]    x_flat,
    output logic [CHANNELS*WIDTH-1:0]    m_flat,
    output logic [CHANNELS*WIDTH-1:0]    n_flat,
    output logic [CHANNELS-1:0]          done,
    output logic [CHANNELS-1:0]          wrap_pulse
);

    localparam logic [WIDTH-1:0] RB = WIDTH'(RESET_BOUND);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] x_q;
        logic [WIDTH-1:0] m_q;
        logic [WIDTH-1:0] n_q;
        logic             wp_q;

        logic [WIDTH-1:0] x_nx;
        logic [WIDTH-1:0] m_nx;
        logic [WIDTH-1:0] n_nx;
        logic             wp_nx;

        logic             bw_hit;
        logic             accept;
        logic             at_last;

        // Out-of-range channel numbers simply never match any channel.
        assign bw_hit  = bound_we && (bound_ch == CW'(i));
        assign accept  = inc_en[i] && (x_q < n_q);
        assign at_last = (x_q == n_q - WIDTH'(1));

        // A bound write clears the channel and wins over that channel's own increment.
        always_comb begin
            x_nx  = x_q;
            m_nx  = m_q;
            n_nx  = n_q;
            wp_nx = 1'b0;
            if (bw_hit) begin
                n_nx = bound_data;
                x_nx = '0;
                m_nx = '0;
            end else if (accept) begin
                if (sel[i]) begin
                    m_nx = x_q;
                end
                if (wrap_mode && at_last) begin
                    x_nx  = '0;
                    wp_nx = 1'b1;
                end else begin
                    x_nx = x_q + WIDTH'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                x_q  <= '0;
                m_q  <= '0;
                n_q  <= RB;
                wp_q <= 1'b0;
            end else begin
                x_q  <= x_nx;
                m_q  <= m_nx;
                n_q  <= n_nx;
                wp_q <= wp_nx;
            end
        end

        assign x_flat[i*WIDTH +: WIDTH] = x_q;
        assign m_flat[i*WIDTH +: WIDTH] = m_q;
        assign n_flat[i*WIDTH +: WIDTH] = n_q;
        assign done[i]                  = (x_q >= n_q);
        assign wrap_pulse[i]            = wp_q;
    end

endmodule

// File: tb/tb_multi_bounded_sample_counter.sv
// Directed plus random bench for multi_bounded_sample_counter, compared every cycle
// against a behavioural per-channel model, with literal expectations pinning key points.
module tb_multi_bounded_sample_counter;

    localparam int W  = 11;
    localparam int CH = 4;
    localparam int RB = 500;

    logic            clk;
    logic            rst;
    logic [CH-1:0]   inc_en;
    logic [CH-1:0]   sel;
    logic            wrap_mode;
    logic            bound_we;
    logic [1:0]      bound_ch;
    logic [W-1:0]    bound_data;
    logic [CH*W-1:0] x_flat;
    logic [CH*W-1:0] m_flat;
    logic [CH*W-1:0] n_flat;
    logic [CH-1:0]   done;
    logic [CH-1:0]   wrap_pulse;

    int checks = 0;
    int passes = 0;

    int mx [CH];
    int mm [CH];
    int mn [CH];
    logic [CH-1:0] mwp;
    bit model_on = 0;

    multi_bounded_sample_counter #(.WIDTH(W), .CHANNELS(CH), .RESET_BOUND(RB)) dut (
        .clk(clk), .rst(rst), .inc_en(inc_en), .sel(sel), .wrap_mode(wrap_mode),
        .bound_we(bound_we), .bound_ch(bound_ch), .bound_data(bound_data),
        .x_flat(x_flat), .m_flat(m_flat), .n_flat(n_flat), .done(done),
        .wrap_pulse(wrap_pulse)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Channel-level rules: clear on reset/bound write, else count toward n and wrap or stop.
    function automatic void model_step();
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                mx[i] = 0; mm[i] = 0; mn[i] = RB; mwp[i] = 1'b0;
            end else if (bound_we && int'(bound_ch) == i) begin
                mn[i] = int'(bound_data); mx[i] = 0; mm[i] = 0; mwp[i] = 1'b0;
            end else begin
                mwp[i] = 1'b0;
                if (inc_en[i] && mx[i] < mn[i]) begin
                    if (sel[i]) mm[i] = mx[i];
                    if (wrap_mode && mx[i] + 1 == mn[i]) begin
                        mx[i] = 0; mwp[i] = 1'b1;
                    end else begin
                        mx[i] = mx[i] + 1;
                    end
                end
            end
        end
    endfunction

    task automatic applyStimulus(input logic r, input logic [CH-1:0] ie, input logic [CH-1:0] s,
                                 input logic wm, input logic we, input logic [1:0] ch,
                                 input logic [W-1:0] d);
        rst = r; inc_en = ie; sel = s; wrap_mode = wm;
        bound_we = we; bound_ch = ch; bound_data = d;
        @(posedge clk);
        model_step();
        if (r) model_on = 1;
        #1;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            logic [CH*W-1:0] ex, em, en;
            logic [CH-1:0]   ed;
            for (int i = 0; i < CH; i++) begin
                ex[i*W +: W] = W'(mx[i]);
                em[i*W +: W] = W'(mm[i]);
                en[i*W +: W] = W'(mn[i]);
                ed[i]        = (mx[i] >= mn[i]);
            end
            checkOutput("model_x", 64'(x_flat), 64'(ex));
            checkOutput("model_m", 64'(m_flat), 64'(em));
            checkOutput("model_n", 64'(n_flat), 64'(en));
            checkOutput("model_done", 64'(done), 64'(ed));
            checkOutput("model_wrap", 64'(wrap_pulse), 64'(mwp));
        end
    end

    function automatic int xof(input int i); return int'(x_flat[i*W +: W]); endfunction
    function automatic int mof(input int i); return int'(m_flat[i*W +: W]); endfunction
    function automatic int nof(input int i); return int'(n_flat[i*W +: W]); endfunction

    initial begin
        int exp_seq [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
        int pulses;
        logic wm;
        bit ok;

        rst = 1; inc_en = '0; sel = '0; wrap_mode = 0; bound_we = 0; bound_ch = '0; bound_data = '0;
        applyStimulus(1, 4'h0, 4'h0, 0, 0, 2'd0, 11'd0);
        for (int i = 0; i < CH; i++) begin
            checkOutput("reset_x", 64'(xof(i)), 64'd0);
            checkOutput("reset_n", 64'(nof(i)), 64'd500);
        end

        for (int c = 0; c < 600; c++) applyStimulus(0, 4'hF, 4'h0, 0, 0, 2'd0, 11'd0);
        for (int i = 0; i < CH; i++) begin
            checkOutput("sat_x", 64'(xof(i)), 64'd500);
            checkOutput("sat_m", 64'(mof(i)), 64'd0);
        end
        checkOutput("sat_done", 64'(done), 64'hF);

        applyStimulus(1, 4'h0, 4'h0, 0, 0, 2'd0, 11'd0);
        for (int c = 0; c < 10; c++) applyStimulus(0, 4'h1, 4'h1, 0, 0, 2'd0, 11'd0);
        checkOutput("ch0_x", 64'(xof(0)), 64'd10);
        checkOutput("ch0_m", 64'(mof(0)), 64'd9);
        checkOutput("ch123_x", 64'(x_flat[CH*W-1:W]), 64'd0);
        applyStimulus(0, 4'h0, 4'h1, 0, 0, 2'd0, 11'd0);
        checkOutput("sel_only_m", 64'(mof(0)), 64'd9);

        applyStimulus(0, 4'h0, 4'h0, 1, 1, 2'd2, 11'd5);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(0, 4'h4, 4'h0, 1, 0, 2'd0, 11'd0);
            checkOutput("wrap_seq", 64'(xof(2)), 64'(exp_seq[c]));
            if (wrap_pulse[2]) pulses++;
        end
        applyStimulus(0, 4'h0, 4'h0, 1, 0, 2'd0, 11'd0);
        if (wrap_pulse[2]) pulses++;
        checkOutput("wrap_pulses", 64'(pulses), 64'd2);

        for (int c = 0; c < 7; c++) applyStimulus(0, 4'h2, 4'h0, 0, 0, 2'd0, 11'd0);
        checkOutput("ch1_pre", 64'(xof(1)), 64'd7);
        applyStimulus(0, 4'h2, 4'h2, 0, 1, 2'd1, 11'd3);
        checkOutput("bw_x1", 64'(xof(1)), 64'd0);
        checkOutput("bw_m1", 64'(mof(1)), 64'd0);
        checkOutput("bw_n1", 64'(nof(1)), 64'd3);

        applyStimulus(0, 4'h0, 4'h0, 0, 1, 2'd3, 11'd0);
        pulses = 0;
        wm = 0;
        for (int c = 0; c < 20; c++) begin
            wm = ~wm;
            applyStimulus(0, 4'h8, 4'h8, wm, 0, 2'd0, 11'd0);
            if (wrap_pulse[3]) pulses++;
        end
        checkOutput("zero_x3", 64'(xof(3)), 64'd0);
        checkOutput("zero_done3", 64'(done[3]), 64'd1);
        checkOutput("zero_pulses3", 64'(pulses), 64'd0);

        applyStimulus(1, 4'h0, 4'h0, 0, 0, 2'd0, 11'd0);
        for (int c = 0; c < 250; c++) applyStimulus(0, 4'h1, 4'h0, 0, 0, 2'd0, 11'd0);
        checkOutput("mid_x0", 64'(xof(0)), 64'd250);
        applyStimulus(1, 4'hF, 4'hF, 1, 1, 2'd0, 11'd7);
        checkOutput("rst_x", 64'(x_flat), 64'd0);
        checkOutput("rst_m", 64'(m_flat), 64'd0);
        for (int i = 0; i < CH; i++) checkOutput("rst_n", 64'(nof(i)), 64'd500);

        wm = 0;
        for (int c = 0; c < 2000; c++) begin
            logic [W-1:0] d;
            if ($urandom_range(0, 49) == 0) wm = ~wm;
            d = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 2047)) : W'($urandom_range(0, 12));
            applyStimulus($urandom_range(0, 199) == 0, CH'($urandom), CH'($urandom), wm,
                          $urandom_range(0, 19) == 0, 2'($urandom), d);
            ok = 1;
            for (int i = 0; i < CH; i++) begin
                if (xof(i) > nof(i)) ok = 0;
                if (nof(i) > 0 && mof(i) >= nof(i)) ok = 0;
                if (!wm && nof(i) > 0 && xof(i) >= nof(i) && mof(i) >= nof(i)) ok = 0;
            end
            checkOutput("invariants", 64'(ok), 64'd1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
